// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants, types and the instruction decoder for the
// ALU issue stage.
//   - SEL_*   : 3-bit ALU selector encodings (add, sub, and, or, xor, sll, srl, slt)
//   - OP_R/OP_I : RV32I opcodes accepted by the issue stage
//   - decode(): classifies an instruction word into legality, operand format
//               and ALU selector
package alu_issue_pkg;

  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_SUB = 3'd1;
  localparam logic [2:0] SEL_AND = 3'd2;
  localparam logic [2:0] SEL_OR  = 3'd3;
  localparam logic [2:0] SEL_XOR = 3'd4;
  localparam logic [2:0] SEL_SLL = 3'd5;
  localparam logic [2:0] SEL_SRL = 3'd6;
  localparam logic [2:0] SEL_SLT = 3'd7;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  // Operand-1 source: rs2, sign-extended imm12, or zero-extended shamt.
  typedef enum logic [1:0] {
    FMT_R     = 2'd0,
    FMT_I_SX  = 2'd1,
    FMT_I_SH  = 2'd2,
    FMT_BAD   = 2'd3
  } fmt_e;

  typedef struct packed {
    logic       legal;
    fmt_e       fmt;
    logic [2:0] sel;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = instr[31:25];
    f3 = instr[14:12];
    d  = '{legal: 1'b0, fmt: FMT_BAD, sel: SEL_ADD};
    if (instr[6:0] == OP_R) begin
      d.fmt = FMT_R;
      if (f3 == 3'b000 && f7 == 7'b0100000) begin
        d.legal = 1'b1;
        d.sel   = SEL_SUB;
      end else if (f7 == 7'b0000000) begin
        d.legal = 1'b1;
        unique case (f3)
          3'b000:  d.sel = SEL_ADD;
          3'b111:  d.sel = SEL_AND;
          3'b110:  d.sel = SEL_OR;
          3'b100:  d.sel = SEL_XOR;
          3'b001:  d.sel = SEL_SLL;
          3'b101:  d.sel = SEL_SRL;
          3'b010:  d.sel = SEL_SLT;
          default: d.legal = 1'b0;   // sltu is not an ALU op here
        endcase
      end
    end else if (instr[6:0] == OP_I) begin
      d.legal = 1'b1;
      d.fmt   = FMT_I_SX;
      unique case (f3)
        3'b000:  d.sel = SEL_ADD;
        3'b111:  d.sel = SEL_AND;
        3'b110:  d.sel = SEL_OR;
        3'b100:  d.sel = SEL_XOR;
        3'b010:  d.sel = SEL_SLT;
        3'b001, 3'b101: begin
          // Shifts take a 5-bit shamt; nonzero upper bits (e.g. srai) are dropped.
          d.fmt   = FMT_I_SH;
          d.sel   = (f3 == 3'b001) ? SEL_SLL : SEL_SRL;
          d.legal = (f7 == 7'b0000000);
        end
        default: d.legal = 1'b0;     // sltiu
      endcase
    end
    if (!d.legal) d.fmt = FMT_BAD;
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 32 x XLEN register file, two combinational read ports, one
// write port. x0 always reads zero and is never written.
//   clk, rst_n      : clock, async active-low reset (clears every register)
//   ra1/rd1, ra2/rd2: read address / data
//   we, wa, wd      : write strobe, address, data
// With BYPASS=1 a read hitting the register being written this cycle returns
// the write data directly.
module alu_regfile #(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs_q[wa] <= wd;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
    if (a == 5'd0)                  return '0;
    else if (BYPASS && we && wa == a) return wd;
    else                            return regs_q[a];
  endfunction

  assign rd1 = rd_port(ra1);
  assign rd2 = rd_port(ra2);

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue stage in front of the ALU. Decodes RV32I R/I-type ALU
// instructions, reads operands, checks RAW hazards against a busy scoreboard
// and presents one registered operand bundle to the ALU.
//   in_valid/in_ready/in_instr : instruction handshake
//   out_valid/out_ready        : operand bundle handshake
//   out_in0/out_in1/out_sel/out_rd : bundle (rs1, rs2-or-imm, selector, dest)
//   wb_en/wb_rd/wb_data        : ALU result writeback
//   illegal                    : one-cycle pulse when a bad instruction is dropped
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_in0,
  output logic [XLEN-1:0] out_in1,
  output logic [2:0]      out_sel,
  output logic [4:0]      out_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  dec_t            dec;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val, op1_val;
  logic [31:0]     busy_q, busy_d, wb_clr, busy_eff;
  logic            stall, accept;
  logic            out_valid_q, out_valid_d, illegal_q, illegal_d;
  logic [XLEN-1:0] out_in0_q, out_in0_d, out_in1_q, out_in1_d;
  logic [2:0]      out_sel_q, out_sel_d;
  logic [4:0]      out_rd_q, out_rd_d;

  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];
  assign dec = decode(in_instr);

  alu_regfile #(.XLEN(XLEN), .BYPASS(BYPASS)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .rd1   (rs1_val),
    .ra2   (rs2),
    .rd2   (rs2_val),
    .we    (wb_en),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  always_comb begin
    op1_val = rs2_val;
    if (dec.fmt == FMT_I_SX)      op1_val = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    else if (dec.fmt == FMT_I_SH) op1_val = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  end

  // A same-cycle writeback releases its register before the hazard check
  // so the dependent instruction issues with the forwarded value.
  assign wb_clr   = wb_en ? (32'd1 << wb_rd) : 32'd0;
  assign busy_eff = BYPASS ? (busy_q & ~wb_clr) : busy_q;

  // Illegal instructions never read operands, so they never stall.
  assign stall    = dec.legal &&
                    (busy_eff[rs1] || (dec.fmt == FMT_R && busy_eff[rs2]));
  assign in_ready = !stall && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = (out_valid_q && !out_ready) || (accept && dec.legal);
    illegal_d   = accept && !dec.legal;
    out_in0_d   = out_in0_q;
    out_in1_d   = out_in1_q;
    out_sel_d   = out_sel_q;
    out_rd_d    = out_rd_q;
    if (accept && dec.legal) begin
      out_in0_d = rs1_val;
      out_in1_d = op1_val;
      out_sel_d = dec.sel;
      out_rd_d  = rd;
    end
    // Clear first, then set, so a same-register set/clear leaves it busy.
    busy_d = busy_q & ~wb_clr;
    if (accept && dec.legal) busy_d = busy_d | (32'd1 << rd);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      out_in0_q   <= '0;
      out_in1_q   <= '0;
      out_sel_q   <= SEL_ADD;
      out_rd_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      out_in0_q   <= out_in0_d;
      out_in1_q   <= out_in1_d;
      out_sel_q   <= out_sel_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_in0   = out_in0_q;
  assign out_in1   = out_in1_q;
  assign out_sel   = out_sel_q;
  assign out_rd    = out_rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_in0, out_in1;
  logic [2:0]  out_sel;
  logic [4:0]  out_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [31:0] S_ADD = 32'd0, S_SUB = 32'd1, S_AND = 32'd2,
                          S_XOR = 32'd4, S_SLL = 32'd5, S_SLT = 32'd7;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32), .BYPASS(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_in0   (out_in0),
    .out_in1   (out_in1),
    .out_sel   (out_sel),
    .out_rd    (out_rd),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Drive all inputs for the coming posedge, from the falling edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    in_valid = v;
    in_instr = ins;
    wb_en    = we;
    wb_rd    = wr;
    wb_data  = wd;
    #1;
  endtask

  // Offer one instruction (optionally with a same-cycle writeback) that must
  // be accepted immediately, then check the registered bundle.
  task automatic issue(input string tag, input logic [31:0] ins,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] esel, input logic [4:0] erd);
    drive(1'b1, ins, we, wr, wd);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in0"}, out_in0, e0);
    check({tag, ".in1"}, out_in1, e1);
    check({tag, ".sel"}, 32'(out_sel), esel);
    check({tag, ".rd"}, 32'(out_rd), 32'(erd));
    $display("issue %-8s instr=%08h in0=%08h in1=%08h sel=%0d rd=%0d",
             tag, ins, out_in0, out_in1, out_sel, out_rd);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    out_ready = 1'b1;
    wb_en     = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in0", out_in0, 32'd0);
    check("rst.in1", out_in1, 32'd0);
    check("rst.sel", 32'(out_sel), S_ADD);
    check("rst.rd", 32'(out_rd), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Seed x1 = x2 = 5.
    drive(1'b0, 32'd0, 1'b1, 5'd1, 32'd5);
    drive(1'b0, 32'd0, 1'b1, 5'd2, 32'd5);

    issue("add3", r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 5'd0, 32'd0,
          32'd5, 32'd5, S_ADD, 5'd3);
    issue("addi4", i_type(12'hFFF, 5'd0, 3'b000, 5'd4), 1'b0, 5'd0, 32'd0,
          32'd0, 32'hFFFF_FFFF, S_ADD, 5'd4);
    issue("slli5", i_type(12'd1, 5'd1, 3'b001, 5'd5), 1'b0, 5'd0, 32'd0,
          32'd5, 32'd1, S_SLL, 5'd5);

    // and x6,x3,x2 must wait for x3; released by a same-cycle writeback.
    drive(1'b1, r_type(7'd0, 5'd2, 5'd3, 3'b111, 5'd6), 1'b0, 5'd0, 32'd0);
    check("haz.stall0", 32'(in_ready), 32'd0);
    drive(1'b1, r_type(7'd0, 5'd2, 5'd3, 3'b111, 5'd6), 1'b0, 5'd0, 32'd0);
    check("haz.stall1", 32'(in_ready), 32'd0);
    issue("and6", r_type(7'd0, 5'd2, 5'd3, 3'b111, 5'd6), 1'b1, 5'd3, 32'd10,
          32'd10, 32'd5, S_AND, 5'd6);

    // Back-pressure: bundle must hold for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, r_type(7'd0, 5'd2, 5'd1, 3'b100, 5'd7), 1'b0, 5'd0, 32'd0);
      out_ready = 1'b0;
      #1;
      check("hold.in_ready", 32'(in_ready), 32'd0);
      check("hold.valid", 32'(out_valid), 32'd1);
      check("hold.in0", out_in0, 32'd10);
      check("hold.rd", 32'(out_rd), 32'd6);
    end
    out_ready = 1'b1;
    issue("xor7", r_type(7'd0, 5'd2, 5'd1, 3'b100, 5'd7), 1'b0, 5'd0, 32'd0,
          32'd5, 32'd5, S_XOR, 5'd7);

    // Illegal instructions: bad opcode, then srai.
    drive(1'b1, 32'h0000_007F, 1'b0, 5'd0, 32'd0);
    check("bad.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bad.illegal", 32'(illegal), 32'd1);
    check("bad.out_valid", 32'(out_valid), 32'd0);
    $display("issue bad      instr=0000007f illegal=%0d", illegal);
    drive(1'b1, i_type({7'b0100000, 5'd2}, 5'd1, 3'b101, 5'd1), 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    check("srai.illegal", 32'(illegal), 32'd1);
    check("srai.out_valid", 32'(out_valid), 32'd0);
    $display("issue srai     illegal=%0d", illegal);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    check("idle.illegal", 32'(illegal), 32'd0);
    // x1 must be neither busy nor modified by the dropped srai.
    issue("add8", r_type(7'd0, 5'd1, 5'd1, 3'b000, 5'd8), 1'b0, 5'd0, 32'd0,
          32'd5, 32'd5, S_ADD, 5'd8);

    // Reset while a bundle is held and x4..x8 are busy.
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.rd", 32'(out_rd), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    issue("add9", r_type(7'd0, 5'd5, 5'd4, 3'b000, 5'd9), 1'b0, 5'd0, 32'd0,
          32'd0, 32'd0, S_ADD, 5'd9);
    issue("addi10", i_type(12'd7, 5'd1, 3'b000, 5'd10), 1'b0, 5'd0, 32'd0,
          32'd0, 32'd7, S_ADD, 5'd10);

    // x0 ignores writes; bypass forwards a same-cycle write to an operand.
    drive(1'b0, 32'd0, 1'b1, 5'd0, 32'd77);
    issue("addi11", i_type(12'd3, 5'd0, 3'b000, 5'd11), 1'b0, 5'd0, 32'd0,
          32'd0, 32'd3, S_ADD, 5'd11);
    issue("addi14", i_type(12'h800, 5'd1, 3'b000, 5'd14), 1'b1, 5'd1, 32'd9,
          32'd9, 32'hFFFF_F800, S_ADD, 5'd14);
    issue("sub12", r_type(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd12), 1'b0, 5'd0, 32'd0,
          32'd0, 32'd9, S_SUB, 5'd12);
    issue("slt13", r_type(7'd0, 5'd0, 5'd1, 3'b010, 5'd13), 1'b0, 5'd0, 32'd0,
          32'd9, 32'd0, S_SLT, 5'd13);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    check("drain.out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
